// File: rtl/aes_pkg.sv
// aes_pkg: GF(2^8) arithmetic, S-boxes, FSM state type and mode encodings
// shared by the AES block engine and its round unit.
package aes_pkg;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    function automatic int nr_from_nk(input int nk);
        return nk + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] acc;
        logic [7:0] x;
        acc = 8'h00;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                acc = acc ^ x;
            end
            x = xtime(x);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(
        input logic [7:0] v,
        input int         n
    );
        return (v << n) | (v >> (8 - n));
    endfunction

    // Inverse as a^254 by square-and-multiply; maps 0 to 0 as AES needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] i;
        i = gf_inv(b);
        return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3)
                 ^ rotl8(i, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_block_engine_round.sv
// aes_round_unit: one combinational AES round, forward or inverse.
// The forward path exists only when AES_ENC_EN is defined.
module aes_round_unit
    import aes_pkg::*;
(
    input  logic [127:0] state_i,
    input  logic [127:0] rkey_i,
    input  logic         dec_i,
    input  logic         final_i,
    output logic [127:0] state_o
);

    // Byte n sits at [127-8n]; column c holds bytes 4c..4c+3, row r = n%4.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[127-8*n -: 8] = sbox(s[127-8*n -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {
            gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)
        };
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
        end
        return o;
    endfunction

    logic [127:0] dec_ak;
    logic [127:0] dec_next;

    // Key is added before InvMixColumns, matching the FIPS inverse cipher.
    assign dec_ak   = inv_sub_bytes(inv_shift_rows(state_i)) ^ rkey_i;
    assign dec_next = final_i ? dec_ak : inv_mix_columns(dec_ak);

`ifdef AES_ENC_EN
    logic [127:0] enc_sr;
    logic [127:0] enc_next;

    assign enc_sr   = shift_rows(sub_bytes(state_i));
    assign enc_next = (final_i ? enc_sr : mix_columns(enc_sr)) ^ rkey_i;
    assign state_o  = (dec_i == MODE_DEC) ? dec_next : enc_next;
`else
    logic unused_dec;

    assign unused_dec = dec_i;
    assign state_o    = dec_next;
`endif

endmodule

// File: rtl/aes_block_engine.sv
// aes_block_engine: iterative AES, one round per clock, valid/ready I/O.
// Define AES_ENC_EN to build the encrypt direction; otherwise decrypt only.
module aes_block_engine
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_mode,
    input  logic [127:0]                      in_data,
    input  logic [128*(nr_from_nk(NK)+1)-1:0] round_keys,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [127:0]                      out_data,
    output logic                              busy
);

    localparam int NR = nr_from_nk(NK);
    localparam int RW = $clog2(NR + 1);
    localparam int KW = 128 * (NR + 1);

    if (NK != 4 && NK != 6 && NK != 8) begin : g_bad_nk
        $error("aes_block_engine: NK must be 4, 6 or 8");
    end

    state_e        st_q, st_d;
    logic [RW-1:0] rnd_q, rnd_d;
    logic [127:0]  data_q, data_d;
    logic          mode_q, mode_d;

    logic [127:0]  keys [NR+1];
    logic [RW-1:0] key_idx;
    logic [127:0]  round_key;
    logic [127:0]  round_out;
    logic          last_round;
    logic          in_mode_eff;

    for (genvar k = 0; k <= NR; k++) begin : g_keys
        assign keys[k] = round_keys[KW-1-128*k -: 128];
    end

    assign last_round = (rnd_q == RW'(NR));
    assign key_idx    = (mode_q == MODE_DEC) ? RW'(NR) - rnd_q : rnd_q;
    assign round_key  = keys[key_idx];

`ifdef AES_ENC_EN
    assign in_mode_eff = in_mode;
`else
    logic unused_in_mode;

    assign unused_in_mode = in_mode;
    assign in_mode_eff    = MODE_DEC;
`endif

    aes_round_unit u_round (
        .state_i (data_q),
        .rkey_i  (round_key),
        .dec_i   (mode_q),
        .final_i (last_round),
        .state_o (round_out)
    );

    always_comb begin
        st_d   = st_q;
        rnd_d  = rnd_q;
        data_d = data_q;
        mode_d = mode_q;
        unique case (st_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mode_d = in_mode_eff;
                    data_d = in_data ^ ((in_mode_eff == MODE_DEC)
                                        ? keys[NR] : keys[0]);
                    rnd_d  = RW'(1);
                    st_d   = ST_ROUND;
                end
            end
            ST_ROUND: begin
                data_d = round_out;
                if (last_round) begin
                    st_d = ST_DONE;
                end else begin
                    rnd_d = rnd_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    st_d = ST_IDLE;
                end
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q   <= ST_IDLE;
            rnd_q  <= '0;
            data_q <= '0;
            mode_q <= MODE_ENC;
        end else begin
            st_q   <= st_d;
            rnd_q  <= rnd_d;
            data_q <= data_d;
            mode_q <= mode_d;
        end
    end

    // Ready depends on registered state only; reset masks it while held.
    assign in_ready  = (st_q == ST_IDLE) && !reset;
    assign out_valid = (st_q == ST_DONE);
    assign out_data  = out_valid ? data_q : '0;
    assign busy      = (st_q != ST_IDLE);

endmodule

// File: tb/tb_aes_block_engine.sv
// tb_aes_block_engine: directed test of NK=4/6/8 engines against FIPS-197
// vectors, with a bench-side key schedule and an expected-result queue.
module tb_aes_block_engine;

    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT [3] = '{
        128'h69c4e0d86a7b0430d8cdb78070b4c55a,
        128'hdda97ca4864cdfe06eaf70a0ec0d7191,
        128'h8ea2b7ca516745bfeafc49904b496089
    };

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic         in_valid  [3];
    logic         in_mode   [3];
    logic         out_ready [3];
    logic [127:0] in_data   [3];
    logic         in_ready  [3];
    logic         out_valid [3];
    logic         busy      [3];
    logic [127:0] out_data  [3];
    logic [1919:0] rk_all   [3];

    logic [127:0] sb [$];
    logic [7:0]   sbox_t [256];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NKG = 4 + 2 * g;
        localparam int KWG = 128 * (NKG + 7);
        aes_block_engine #(.NK(NKG)) u_dut (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (in_valid[g]),
            .in_ready   (in_ready[g]),
            .in_mode    (in_mode[g]),
            .in_data    (in_data[g]),
            .round_keys (rk_all[g][1919 -: KWG]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_data   (out_data[g]),
            .busy       (busy[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from the generator-3 walk: p steps by *3, q by /3.
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl8(q, 1) ^ rl8(q, 2) ^ rl8(q, 3) ^ rl8(q, 4);
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]],
                sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Key bytes are 00,01,02,... as in the FIPS-197 appendix C vectors.
    function automatic logic [1919:0] expand(input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1919:0] rk;
        int            nr;
        nr = nk + 6;
        rc = 8'h01;
        rk = '0;
        for (int i = 0; i < nk; i++)
            w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k <= nr; k++)
            rk[1919-128*k -: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return rk;
    endfunction

    // An encrypt request is decrypted when the encrypt path is not built.
    task automatic enc_req(input int i, output logic [127:0] din,
                           output logic [127:0] exp);
`ifdef AES_ENC_EN
        din = PT;
        exp = CT[i];
`else
        din = CT[i];
        exp = PT;
`endif
    endtask

    task automatic accept(input int i, input logic mode,
                          input logic [127:0] din, input logic [127:0] exp,
                          input bit push);
        int w = 0;
        in_valid[i] = 1'b1;
        in_mode[i]  = mode;
        in_data[i]  = din;
        while (!in_ready[i] && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        chk("ready_wait", 128'(w < 40), 128'd1);
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        in_mode[i]  = ~mode;
        in_data[i]  = {$urandom, $urandom, $urandom, $urandom};
        if (push) sb.push_back(exp);
    endtask

    task automatic wait_valid(input int i, input int nr);
        int cnt = 1;
        while (!out_valid[i] && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        chk("latency", 128'(cnt), 128'(nr + 1));
    endtask

    task automatic pop_check(input int i);
        logic [127:0] exp;
        chk("sb_nonempty", 128'(sb.size() > 0), 128'd1);
        exp = '0;
        if (sb.size() > 0) exp = sb.pop_front();
        chk("out_data", out_data[i], exp);
    endtask

    task automatic collect(input int i, input int nr);
        wait_valid(i, nr);
        pop_check(i);
        out_ready[i] = 1'b1;
        @(posedge clk); #1;
        out_ready[i] = 1'b0;
        chk("out_valid_drop", 128'(out_valid[i]), 128'd0);
        chk("in_ready_after", 128'(in_ready[i]), 128'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] d;
        logic [127:0] e;
        logic [127:0] d2;
        logic [127:0] e2;
        logic         mode;
        logic         seen;
        int           acc [4];
        int           w;

        reset = 1'b1;
        build_sbox();
        for (int i = 0; i < 3; i++) begin
            rk_all[i]    = expand(4 + 2 * i);
            in_valid[i]  = 1'b0;
            in_mode[i]   = 1'b0;
            out_ready[i] = 1'b0;
            in_data[i]   = '0;
        end
        #12;
        for (int i = 0; i < 3; i++) begin
            chk("rst_in_ready", 128'(in_ready[i]), 128'd0);
            chk("rst_out_valid", 128'(out_valid[i]), 128'd0);
            chk("rst_busy", 128'(busy[i]), 128'd0);
            chk("rst_out_data", out_data[i], 128'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++)
            chk("idle_in_ready", 128'(in_ready[i]), 128'd1);

        // Single blocks, each key size, both directions.
        for (int i = 0; i < 3; i++) begin
            enc_req(i, d, e);
            accept(i, 1'b0, d, e, 1'b1);
            collect(i, 10 + 2 * i);
            accept(i, 1'b1, CT[i], PT, 1'b1);
            collect(i, 10 + 2 * i);
        end

        // Back-pressure on NK=4 with a second block waiting.
        accept(0, 1'b1, CT[0], PT, 1'b1);
        wait_valid(0, 10);
        enc_req(0, d2, e2);
        in_valid[0] = 1'b1;
        in_mode[0]  = 1'b0;
        in_data[0]  = d2;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            chk("bp_out_valid", 128'(out_valid[0]), 128'd1);
            chk("bp_out_data", out_data[0], PT);
            chk("bp_in_ready", 128'(in_ready[0]), 128'd0);
        end
        pop_check(0);
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        chk("bp_release_valid", 128'(out_valid[0]), 128'd0);
        chk("bp_release_busy", 128'(busy[0]), 128'd0);
        chk("bp_release_ready", 128'(in_ready[0]), 128'd1);
        accept(0, 1'b0, d2, e2, 1'b1);
        collect(0, 10);

        // Back-to-back on NK=6, alternating modes, out_ready tied high.
        out_ready[1] = 1'b1;
        in_valid[1]  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mode = k[0];
            if (mode) begin
                d = CT[1];
                e = PT;
            end else begin
                enc_req(1, d, e);
            end
            in_mode[1] = mode;
            in_data[1] = d;
            w = 0;
            while (!in_ready[1] && w < 40) begin
                @(posedge clk); #1;
                w++;
            end
            chk("b2b_ready_wait", 128'(w < 40), 128'd1);
            @(posedge clk); #1;
            acc[k] = cyc;
            sb.push_back(e);
            wait_valid(1, 12);
            pop_check(1);
            if (k > 0)
                chk("b2b_spacing", 128'(acc[k] - acc[k-1]), 128'd14);
        end
        in_valid[1] = 1'b0;
        @(posedge clk); #1;
        out_ready[1] = 1'b0;
        chk("b2b_end_ready", 128'(in_ready[1]), 128'd1);

        // Reset during round 5 of an NK=4 block.
        accept(0, 1'b1, CT[0], PT, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("mid_busy", 128'(busy[0]), 128'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_out_valid", 128'(out_valid[0]), 128'd0);
        chk("abort_out_data", out_data[0], 128'd0);
        chk("abort_busy", 128'(busy[0]), 128'd0);
        chk("abort_in_ready", 128'(in_ready[0]), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (16) begin
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b0) seen = 1'b1;
        end
        chk("no_stale_output", 128'(seen), 128'd0);
        enc_req(0, d, e);
        accept(0, 1'b0, d, e, 1'b1);
        collect(0, 10);
        chk("sb_drained", 128'(sb.size()), 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
